// File: rtl/counter_pkg.sv
// Shared constants and types for the up/down counter slice.
package counter_pkg;

  // Default counter width in bits.
  localparam int WIDTH_DEFAULT = 8;

  // Counting direction, matching the encoding of the 'up' input.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage : counter_pkg

// File: rtl/addsub_n.sv
// WIDTH-bit increment/decrement datapath built as a ripple of full_adder cells.
// Increment adds 1; decrement adds all-ones (two's-complement -1). The
// carry out of the top cell is exposed so the caller can detect boundaries.
module addsub_n
  import counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  dir_e             dir,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic [WIDTH-1:0] operand_s;
  logic [WIDTH:0]   carry_s;

  // Select the addend: +1 when counting up, all-ones when counting down.
  always_comb begin
    operand_s = {WIDTH{1'b1}};
    if (dir == DIR_UP) begin
      operand_s = {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      operand_s = {WIDTH{1'b1}};
    end
  end

  assign carry_s[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder u_fa (
      .a    (a[i]),
      .b    (operand_s[i]),
      .cin  (carry_s[i]),
      .s    (sum[i]),
      .cout (carry_s[i+1])
    );
  end

  assign carry_out = carry_s[WIDTH];

endmodule : addsub_n

// File: rtl/full_adder.sv
// One-bit full adder cell used to build ripple datapaths.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/updown_counter_n.sv
// Loadable WIDTH-bit up/down counter with a registered boundary pulse.
// Optional feature macro: COUNTER_SAT_EN -- when defined the count saturates
// at 0 / max instead of wrapping, and wrap pulses on every enabled step
// attempted at a boundary.
module updown_counter_n
  import counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             up,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             zero
);

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic [WIDTH-1:0] sum_s;
  logic             carry_s;
  logic             boundary_s;
  logic [WIDTH-1:0] q_next_s;
  dir_e             dir_s;

  assign dir_s = dir_e'(up);

  addsub_n #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a         (q_r),
    .dir       (dir_s),
    .sum       (sum_s),
    .carry_out (carry_s)
  );

  // Boundary from the adder carry: a carry going up is overflow, a missing
  // carry going down (adding all-ones to zero) is underflow.
  always_comb begin
    boundary_s = 1'b0;
    if (dir_s == DIR_UP) begin
      boundary_s = carry_s;
    end else begin
      boundary_s = ~carry_s;
    end
  end

  // Next count for an enabled step: modulo result, or held value at a boundary when saturating.
  always_comb begin
    q_next_s = sum_s;
`ifdef COUNTER_SAT_EN
    if (boundary_s) begin
      q_next_s = q_r;
    end else begin
      q_next_s = sum_s;
    end
`else
    q_next_s = sum_s;
`endif
  end

  // Count and boundary-pulse registers; load has priority over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r    <= {WIDTH{1'b0}};
      wrap_r <= 1'b0;
    end else if (load) begin
      q_r    <= din;
      wrap_r <= 1'b0;
    end else if (en) begin
      q_r    <= q_next_s;
      wrap_r <= boundary_s;
    end else begin
      q_r    <= q_r;
      wrap_r <= 1'b0;
    end
  end

  assign q    = q_r;
  assign wrap = wrap_r;
  assign zero = (q_r == {WIDTH{1'b0}});

endmodule : updown_counter_n

// File: tb/tb_updown_counter_n.sv
// Directed self-checking bench for updown_counter_n at WIDTH=4.
// Expectations follow the build: modulo by default, saturating when
// COUNTER_SAT_EN is defined.
module tb_updown_counter_n;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         load;
  logic         up;
  logic [W-1:0] din;
  logic [W-1:0] q;
  logic         wrap;
  logic         zero;

  int cmp_cnt;
  int err_cnt;

`ifdef COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  updown_counter_n #(
    .WIDTH (W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .load (load),
    .up   (up),
    .din  (din),
    .q    (q),
    .wrap (wrap),
    .zero (zero)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if observed differs from expected.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of controls, then check q, wrap and zero.
  task automatic cyc(input string tag, input logic l, input logic e, input logic u,
                     input logic [W-1:0] d, input logic [W-1:0] exp_q, input logic exp_w);
    load = l;
    en   = e;
    up   = u;
    din  = d;
    tick();
    chk({tag, ".q"}, 32'(q), 32'(exp_q));
    chk({tag, ".wrap"}, 32'(wrap), 32'(exp_w));
    chk({tag, ".zero"}, 32'(zero), 32'(exp_q == 4'h0));
  endtask

  initial begin
    cmp_cnt = 0;
    err_cnt = 0;
    rst  = 1'b1;
    en   = 1'b0;
    load = 1'b0;
    up   = 1'b0;
    din  = 4'h0;
    #12;
    chk("reset.q", 32'(q), 32'h0);
    chk("reset.zero", 32'(zero), 32'h1);
    chk("reset.wrap", 32'(wrap), 32'h0);
    rst = 1'b0;

    // Count to 0x9, then reset asynchronously mid-count.
    cyc("ld7", 1'b1, 1'b0, 1'b1, 4'h7, 4'h7, 1'b0);
    cyc("up8", 1'b0, 1'b1, 1'b1, 4'h0, 4'h8, 1'b0);
    cyc("up9", 1'b0, 1'b1, 1'b1, 4'h0, 4'h9, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst.q", 32'(q), 32'h0);
    chk("arst.zero", 32'(zero), 32'h1);
    chk("arst.wrap", 32'(wrap), 32'h0);
    #1;
    rst = 1'b0;
    // First edge after reset release is a normal count step.
    cyc("post_rst", 1'b0, 1'b1, 1'b1, 4'h0, 4'h1, 1'b0);

    // Load has priority over enable.
    cyc("ld_prio", 1'b1, 1'b1, 1'b1, 4'hA, 4'hA, 1'b0);

    // Down across zero.
    cyc("ld0", 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    cyc("dn_b1", 1'b0, 1'b1, 1'b0, 4'h0, SAT ? 4'h0 : 4'hF, 1'b1);
    cyc("dn_b2", 1'b0, 1'b1, 1'b0, 4'h0, SAT ? 4'h0 : 4'hE, SAT);

    // Up across max.
    cyc("ldE", 1'b1, 1'b0, 1'b1, 4'hE, 4'hE, 1'b0);
    cyc("up_b1", 1'b0, 1'b1, 1'b1, 4'h0, 4'hF, 1'b0);
    cyc("up_b2", 1'b0, 1'b1, 1'b1, 4'h0, SAT ? 4'hF : 4'h0, 1'b1);
    cyc("up_b3", 1'b0, 1'b1, 1'b1, 4'h0, SAT ? 4'hF : 4'h1, SAT);

    // Down from 1 for three cycles.
    cyc("ld1", 1'b1, 1'b0, 1'b0, 4'h1, 4'h1, 1'b0);
    cyc("dn1_a", 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    cyc("dn1_b", 1'b0, 1'b1, 1'b0, 4'h0, SAT ? 4'h0 : 4'hF, 1'b1);
    cyc("dn1_c", 1'b0, 1'b1, 1'b0, 4'h0, SAT ? 4'h0 : 4'hE, SAT);

    // Direction toggle with no idle cycle, then hold.
    cyc("ld5", 1'b1, 1'b0, 1'b0, 4'h5, 4'h5, 1'b0);
    cyc("tog_u", 1'b0, 1'b1, 1'b1, 4'h0, 4'h6, 1'b0);
    cyc("tog_d", 1'b0, 1'b1, 1'b0, 4'h0, 4'h5, 1'b0);
    cyc("tog_u2", 1'b0, 1'b1, 1'b1, 4'h0, 4'h6, 1'b0);
    cyc("hold1", 1'b0, 1'b0, 1'b1, 4'h0, 4'h6, 1'b0);
    cyc("hold2", 1'b0, 1'b0, 1'b0, 4'h0, 4'h6, 1'b0);

    // Load at max with en/up set must not pulse wrap.
    cyc("ldF", 1'b1, 1'b0, 1'b1, 4'hF, 4'hF, 1'b0);
    cyc("ld_at_max", 1'b1, 1'b1, 1'b1, 4'h3, 4'h3, 1'b0);
    // Hold after a boundary pulse clears wrap.
    cyc("ld0b", 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    cyc("dn_pulse", 1'b0, 1'b1, 1'b0, 4'h0, SAT ? 4'h0 : 4'hF, 1'b1);
    cyc("hold_clr", 1'b0, 1'b0, 1'b0, 4'h0, SAT ? 4'h0 : 4'hF, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule : tb_updown_counter_n
